// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI sequencer state encoding and mode bit positions
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } spi_state_t;

    localparam int MODE_CKP = 1;
    localparam int MODE_CPH = 0;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_winner,
    output logic             o_valid
);

    int w_dist;
    int w_best;

    // Smallest forward distance from ptr wins; strict compare keeps the first hit.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_best   = NREQ;
        w_dist   = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j + NREQ - int'(i_ptr)) % NREQ;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_winner    = '0;
                o_winner[j] = 1'b1;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// rtl/spi_request_arbiter.sv - round-robin sequencer sharing one SPI master among NREQ requesters
module spi_request_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [8*NREQ-1:0]   i_req_data,
    input  logic [2*NREQ-1:0]   i_req_mode,
    output logic [NREQ-1:0]     o_grant,
    output logic [NREQ-1:0]     o_done,
    output logic [NREQ-1:0]     o_err,
    output logic                o_busy,
    output logic                o_spi_strt,
    output logic [7:0]          o_spi_data,
    output logic                o_spi_ckp,
    output logic                o_spi_cph,
    input  logic                i_spi_cs,
    output logic [NREQ-1:0]     o_ss_n
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    spi_state_t        r_state;
    spi_state_t        w_next_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_err;
    logic [NREQ-1:0]   w_winner;
    logic              w_valid;
    logic [7:0]        r_data;
    logic [7:0]        w_sel_data;
    logic [1:0]        r_mode;
    logic [1:0]        w_sel_mode;
    logic [GAP_W-1:0]  r_gap;
    logic [WD_W-1:0]   r_wd;
    logic              w_in_xfer;
    logic              w_complete;
    logic              w_timeout;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_mode = '0;
        w_next_ptr = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_winner[j]) begin
                w_sel_data = i_req_data[8*j +: 8];
                w_sel_mode = i_req_mode[2*j +: 2];
                w_next_ptr = PTR_W'((j + 1) % NREQ);
            end
        end
    end

    // A completion seen on the final watchdog cycle still counts as a normal finish.
    assign w_in_xfer  = (r_state == ST_LAUNCH) || (r_state == ST_ACTIVE);
    assign w_complete = (r_state == ST_ACTIVE) && i_spi_cs;
    assign w_timeout  = w_in_xfer && (r_wd == WD_LAST) && !w_complete;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next_state = ST_LAUNCH;
            ST_LAUNCH: begin
                if (w_timeout)      w_next_state = ST_GAP;
                else if (!i_spi_cs) w_next_state = ST_ACTIVE;
            end
            ST_ACTIVE: if (w_complete || w_timeout) w_next_state = ST_GAP;
            ST_GAP:    if (r_gap == GAP_LAST) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_spi_strt = (r_state == ST_LAUNCH);
        o_busy     = (r_state != ST_IDLE);
        o_ss_n     = '1;
        for (int j = 0; j < NREQ; j++) begin
            if (r_grant[j]) o_ss_n[j] = i_spi_cs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_data  <= '0;
            r_mode  <= '0;
            r_gap   <= '0;
            r_wd    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_winner;
                        r_data  <= w_sel_data;
                        r_mode  <= w_sel_mode;
                        r_ptr   <= w_next_ptr;
                        r_wd    <= '0;
                    end
                end
                ST_LAUNCH, ST_ACTIVE: begin
                    if (w_complete || w_timeout) begin
                        r_done  <= w_complete ? r_grant : '0;
                        r_err   <= w_timeout  ? r_grant : '0;
                        r_grant <= '0;
                        r_gap   <= '0;
                    end else if (r_wd != WD_MAX) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap != GAP_MAX) r_gap <= r_gap + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_grant    = r_grant;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_spi_data = r_data;
    assign o_spi_ckp  = r_mode[MODE_CKP];
    assign o_spi_cph  = r_mode[MODE_CPH];

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb/tb_spi_request_arbiter.sv - randomized self-checking bench for spi_request_arbiter
module tb_spi_request_arbiter;

    localparam int NREQ    = 4;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [2*NREQ-1:0] req_mode = '0;
    logic [NREQ-1:0]   grant, done, err, ss_n;
    logic              busy, spi_strt, spi_ckp, spi_cph;
    logic              spi_cs = 1'b1;
    logic [7:0]        spi_data;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [7:0] m_bytes [NREQ];
    logic [1:0] m_modes [NREQ];

    always #5 clk = ~clk;

    spi_request_arbiter #(
        .NREQ    (NREQ),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_req_data (req_data),
        .i_req_mode (req_mode),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_spi_strt (spi_strt),
        .o_spi_data (spi_data),
        .o_spi_ckp  (spi_ckp),
        .o_spi_cph  (spi_cph),
        .i_spi_cs   (spi_cs),
        .o_ss_n     (ss_n)
    );

    function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_data[8*i +: 8] = m_bytes[i];
            req_mode[2*i +: 2] = m_modes[i];
        end
    endtask

    task automatic apply_reset();
        req = '0;
        spi_cs = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g, output int steps);
        steps = 0;
        do begin
            tick();
            steps++;
        end while (grant == '0 && steps < 200);
        g = grant;
    endtask

    task automatic test_reset();
        req = '0;
        spi_cs = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %0h expected 0", grant); end
        checks++; if ((done | err) !== '0) begin errors++; $display("FAIL reset_done_err: got %0h/%0h expected 0/0", done, err); end
        checks++; if ({busy, spi_strt} !== 2'b00) begin errors++; $display("FAIL reset_busy_strt: got %0b expected 00", {busy, spi_strt}); end
        checks++; if ({spi_data, spi_ckp, spi_cph} !== 10'h0) begin errors++; $display("FAIL reset_spi_regs: got %0h expected 0", {spi_data, spi_ckp, spi_cph}); end
        checks++; if (ss_n !== '1) begin errors++; $display("FAIL reset_ss_n: got %0b expected 1111", ss_n); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] dor;
        int steps;
        int dcount;
        apply_reset();
        m_bytes[2] = 8'hA5;
        m_modes[2] = 2'b10;
        pack();
        req = 4'b0100;
        wait_grant(g, steps);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %0b expected 0100", g); end
        checks++; if (steps !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", steps); end
        checks++; if (spi_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", spi_data); end
        checks++; if ({spi_ckp, spi_cph} !== 2'b10) begin errors++; $display("FAIL single_mode: got %0b expected 10", {spi_ckp, spi_cph}); end
        checks++; if (spi_strt !== 1'b1) begin errors++; $display("FAIL single_strt_high: got %0b expected 1", spi_strt); end
        spi_cs = 1'b0;
        tick();
        checks++; if (spi_strt !== 1'b0) begin errors++; $display("FAIL single_strt_drop: got %0b expected 0", spi_strt); end
        checks++; if (ss_n !== 4'b1011) begin errors++; $display("FAIL single_ss_n: got %0b expected 1011", ss_n); end
        repeat (39) tick();
        spi_cs = 1'b1;
        req = '0;
        dcount = 0;
        dor = '0;
        for (int k = 0; k < GAP_CYC + 3; k++) begin
            tick();
            if (done != '0) begin
                dcount++;
                dor |= done;
            end
        end
        checks++; if (dcount !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dcount); end
        checks++; if (dor !== 4'b0100) begin errors++; $display("FAIL single_done_owner: got %0b expected 0100", dor); end
        checks++; if ({busy, ss_n} !== 5'b01111) begin errors++; $display("FAIL single_idle_after: got %0b expected 01111", {busy, ss_n}); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] g;
        int steps;
        int exp;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_bytes[i] = 8'($urandom_range(0, 255));
            m_modes[i] = 2'($urandom_range(0, 3));
        end
        pack();
        req = '1;
        for (int t = 0; t < NREQ; t++) begin
            exp = model_pick(req, m_ptr);
            wait_grant(g, steps);
            checks++; if (g !== (NREQ'(1) << t)) begin errors++; $display("FAIL rr_order_%0d: got %0b expected %0b", t, g, NREQ'(1) << t); end
            checks++; if (g !== (NREQ'(1) << exp)) begin errors++; $display("FAIL rr_model_%0d: got %0b expected %0b", t, g, NREQ'(1) << exp); end
            if (t > 0) begin
                checks++; if (steps !== GAP_CYC + 1) begin errors++; $display("FAIL rr_gap_%0d: got %0d idle cycles expected %0d", t, steps, GAP_CYC + 1); end
            end
            checks++; if (spi_data !== m_bytes[exp]) begin errors++; $display("FAIL rr_data_%0d: got %0h expected %0h", t, spi_data, m_bytes[exp]); end
            m_ptr = (exp + 1) % NREQ;
            spi_cs = 1'b0;
            repeat ($urandom_range(1, 8)) tick();
            spi_cs = 1'b1;
            req[exp] = 1'b0;
            tick();
            checks++; if (done !== (NREQ'(1) << exp)) begin errors++; $display("FAIL rr_done_%0d: got %0b expected %0b", t, done, NREQ'(1) << exp); end
        end
        repeat (GAP_CYC + 2) tick();
    endtask

    task automatic test_starvation();
        logic [NREQ-1:0] g;
        int steps;
        apply_reset();
        req = 4'b0001;
        wait_grant(g, steps);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL starve_first: got %0b expected 0001", g); end
        spi_cs = 1'b0;
        tick();
        req[3] = 1'b1;
        repeat (5) tick();
        spi_cs = 1'b1;
        tick();
        wait_grant(g, steps);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL starve_req3: got %0b expected 1000", g); end
        spi_cs = 1'b0;
        repeat (5) tick();
        spi_cs = 1'b1;
        req[3] = 1'b0;
        tick();
        wait_grant(g, steps);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL starve_req0_again: got %0b expected 0001", g); end
        spi_cs = 1'b0;
        repeat (3) tick();
        spi_cs = 1'b1;
        req = '0;
        repeat (GAP_CYC + 3) tick();
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] err_val;
        logic strt_at;
        int steps;
        int first_err;
        int err_pulses;
        int dones;
        int early_drop;
        apply_reset();
        req = 4'b0010;
        wait_grant(g, steps);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL timeout_grant: got %0b expected 0010", g); end
        first_err = -1;
        err_pulses = 0;
        dones = 0;
        early_drop = 0;
        err_val = '0;
        strt_at = 1'b1;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            tick();
            if (done != '0) dones++;
            if (k < TIMEOUT && spi_strt !== 1'b1) early_drop++;
            if (err != '0) begin
                err_pulses++;
                if (first_err < 0) begin
                    first_err = k;
                    err_val = err;
                    strt_at = spi_strt;
                    req = '0;
                end
            end
        end
        checks++; if (first_err !== TIMEOUT) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", first_err, TIMEOUT); end
        checks++; if (err_val !== 4'b0010) begin errors++; $display("FAIL timeout_owner: got %0b expected 0010", err_val); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", err_pulses); end
        checks++; if (strt_at !== 1'b0) begin errors++; $display("FAIL timeout_strt: got %0b expected 0", strt_at); end
        checks++; if (dones !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", dones); end
        checks++; if (early_drop !== 0) begin errors++; $display("FAIL timeout_strt_held: got %0d low cycles expected 0", early_drop); end
        repeat (GAP_CYC + 2) tick();
    endtask

    task automatic test_data_hold();
        logic [NREQ-1:0] g;
        int steps;
        apply_reset();
        m_bytes[0] = 8'h3C;
        m_modes[0] = 2'b01;
        pack();
        req = 4'b0001;
        wait_grant(g, steps);
        checks++; if (spi_data !== 8'h3C) begin errors++; $display("FAIL hold_data_launch: got %0h expected 3c", spi_data); end
        spi_cs = 1'b0;
        repeat (3) tick();
        req_data[7:0] = 8'h00;
        req = '0;
        repeat (4) tick();
        checks++; if ({grant, spi_data} !== {4'b0001, 8'h3C}) begin errors++; $display("FAIL hold_active: got %0h expected 13c", {grant, spi_data}); end
        spi_cs = 1'b1;
        tick();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL hold_done: got %0b expected 0001", done); end
        checks++; if (spi_data !== 8'h3C) begin errors++; $display("FAIL hold_data_gap: got %0h expected 3c", spi_data); end
        repeat (GAP_CYC + 2) tick();
        checks++; if ({busy, grant} !== 5'b0) begin errors++; $display("FAIL hold_no_regrant: got %0b expected 0", {busy, grant}); end
    endtask

    task automatic test_async_reset();
        logic [NREQ-1:0] g;
        int steps;
        apply_reset();
        m_bytes[2] = 8'h5A;
        m_modes[2] = 2'b11;
        pack();
        req = 4'b0001;
        wait_grant(g, steps);
        spi_cs = 1'b0;
        repeat (2) tick();
        spi_cs = 1'b1;
        req = '0;
        tick();
        repeat (GAP_CYC + 1) tick();
        m_ptr = 1;
        req = 4'b0100;
        wait_grant(g, steps);
        checks++; if (g !== (NREQ'(1) << model_pick(req, m_ptr))) begin errors++; $display("FAIL areset_pre_grant: got %0b expected 0100", g); end
        spi_cs = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({grant, busy, spi_strt} !== 6'b0) begin errors++; $display("FAIL areset_ctrl: got %0b expected 0", {grant, busy, spi_strt}); end
        checks++; if ({spi_data, spi_ckp, spi_cph} !== 10'h0) begin errors++; $display("FAIL areset_spi_regs: got %0h expected 0", {spi_data, spi_ckp, spi_cph}); end
        checks++; if (ss_n !== '1) begin errors++; $display("FAIL areset_ss_n: got %0b expected 1111", ss_n); end
        spi_cs = 1'b1;
        req = 4'b1001;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        wait_grant(g, steps);
        checks++; if (g !== (NREQ'(1) << model_pick(req, m_ptr))) begin errors++; $display("FAIL areset_ptr_zero: got %0b expected 0001", g); end
        spi_cs = 1'b0;
        tick();
        spi_cs = 1'b1;
        req = '0;
        repeat (GAP_CYC + 3) tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] onehot;
        logic [NREQ-1:0] nxt;
        logic [7:0] exp_byte;
        logic [1:0] exp_mode;
        int steps;
        int exp;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_bytes[i] = 8'($urandom_range(0, 255));
            m_modes[i] = 2'($urandom_range(0, 3));
        end
        pack();
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int t = 0; t < 24; t++) begin
            exp = model_pick(req, m_ptr);
            exp_byte = m_bytes[exp];
            exp_mode = m_modes[exp];
            onehot = NREQ'(1) << exp;
            wait_grant(g, steps);
            checks++; if (g !== onehot) begin errors++; $display("FAIL rand_grant_%0d: got %0b expected %0b", t, g, onehot); end
            checks++; if ({spi_data, spi_ckp, spi_cph} !== {exp_byte, exp_mode}) begin errors++; $display("FAIL rand_latch_%0d: got %0h expected %0h", t, {spi_data, spi_ckp, spi_cph}, {exp_byte, exp_mode}); end
            m_ptr = (exp + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) m_bytes[i] = 8'($urandom_range(0, 255));
            pack();
            spi_cs = 1'b0;
            repeat ($urandom_range(1, 30)) tick();
            checks++; if (ss_n !== ~onehot) begin errors++; $display("FAIL rand_ss_n_%0d: got %0b expected %0b", t, ss_n, ~onehot); end
            checks++; if ({spi_data, spi_ckp, spi_cph} !== {exp_byte, exp_mode}) begin errors++; $display("FAIL rand_stable_%0d: got %0h expected %0h", t, {spi_data, spi_ckp, spi_cph}, {exp_byte, exp_mode}); end
            spi_cs = 1'b1;
            nxt = req & ~onehot;
            if ($urandom_range(0, 1) == 1) nxt |= NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (nxt == '0) nxt = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = nxt;
            for (int i = 0; i < NREQ; i++) m_modes[i] = 2'($urandom_range(0, 3));
            pack();
            tick();
            checks++; if (done !== onehot) begin errors++; $display("FAIL rand_done_%0d: got %0b expected %0b", t, done, onehot); end
            if ($urandom_range(0, 2) == 0) begin
                spi_cs = 1'b0;
                #1;
                checks++; if (ss_n !== '1) begin errors++; $display("FAIL rand_spurious_ss_%0d: got %0b expected 1111", t, ss_n); end
                tick();
                spi_cs = 1'b1;
            end
        end
        spi_cs = 1'b0;
        tick();
        spi_cs = 1'b1;
        req = '0;
        repeat (GAP_CYC + 3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            m_bytes[i] = '0;
            m_modes[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_timeout();
        test_data_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
